io_port_bank: RTL
=================

# io_port_bank

Parametrised memory-mapped I/O port bank for the basic processor. It sits on the shared `sysbus` beside the RAM and answers a contiguous window of the address space. The window holds N_IN debounced, synchronised input ports, N_OUT read-back output registers and one change-status register. Each input port raises a change flag and `irq` when its debounced value changes.

## Interface
- `WORD_W`, 8: data/bus width.
- `OP_W`, 3: opcode width; the address width is `A_W = WORD_W-OP_W`.
- `N_IN`, 2: number of input ports, 1..WORD_W.
- `N_OUT`, 2: number of output ports, ≥1.
- `BASE_ADDR`, 24: first address of the window; `BASE_ADDR+N_IN+N_OUT` ≤ 2^A_W−1.
- `DEB_CYCLES`, 4: consecutive stable cycles required to accept an input change, ≥1.
- `clock` input 1: system clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `MDR_bus` input 1: drive the local MDR onto `sysbus` if the MAR hits the window.
- `load_MAR` input 1: capture `sysbus[A_W-1:0]` into the local MAR.
- `load_MDR` input 1: capture `sysbus` into the local MDR.
- `CS` input 1: access strobe.
- `R_NW` input 1: 1 = read a register into the MDR; 0 = write the MDR into a register.
- `sw_in` input N_IN*WORD_W: raw asynchronous inputs; port i is `[i*WORD_W +: WORD_W]`.
- `port_out` output N_OUT*WORD_W: output registers, same packing as `sw_in`.
- `irq` output 1: registered OR of the status flags.
- `sysbus` inout WORD_W: shared bus; high-Z unless this block is driving it.

## Operation
- Address map, as offsets from BASE_ADDR:
  - 0..N_IN−1: input ports, read-only.
  - N_IN..N_IN+N_OUT−1: output registers, read/write.
  - N_IN+N_OUT: STATUS. Bit i is the change flag of input i; unused bits read 0.
- `hit` is true when the MAR lies inside the window. Accesses that miss the window do nothing.
- Register update priority per clock: `load_MAR` > `load_MDR` > `CS`.
- Read access (`CS & R_NW & hit`):
  - MDR ← the selected register.
  - Input ports return their debounced value.
  - A STATUS read returns the flags and clears all of them in the same cycle.
- Write access (`CS & ~R_NW & hit`):
  - Output register ← MDR.
  - A STATUS write clears each flag whose MDR bit is 1 (write-1-to-clear).
  - Writes to input ports are ignored.
- `sysbus` = MDR when `MDR_bus & hit`, otherwise high-Z. This path is purely combinational.
- Input path, per port:
  - A 2-flop synchroniser feeds a debouncer that holds `stable` and a counter.
  - If the synchronised value equals `stable`, the counter goes to 0.
  - Otherwise the counter increments. On the DEB_CYCLES-th consecutive differing cycle, `stable` ← synchronised value, the counter goes to 0 and a one-cycle `changed` pulse is issued.
  - A new differing value during counting restarts the count only if it equals `stable`. Any non-stable value continues the count, and the value sampled on the accepting cycle is the one taken.
- Flag rules:
  - A `changed` pulse sets flag i.
  - If a set and a clear (read or W1C) hit the same flag in the same cycle, the set wins.
- `irq` is registered: it equals `|flags` from the previous cycle.

## Timing
- Reset values are all zero: MAR, MDR, `port_out`, synchroniser flops, `stable`, counters, flags and `irq`. `sysbus` is high-Z during reset.
- An asserted `reset` mid-debounce or mid-access aborts it. No flag survives reset.
- Register read: MDR is valid on the clock after `CS` and can be driven onto `sysbus` in the following cycle.
- Output write: `port_out` updates on the clock edge where `CS & ~R_NW` is sampled.
- Input latency: a raw input change held steady appears in `stable` after 2 + DEB_CYCLES clocks. The flag sets on that same edge, and `irq` rises one clock later.
- A glitch shorter than DEB_CYCLES synchronised cycles produces no change and no flag.
- At the window edges, BASE_ADDR−1 and BASE_ADDR+N_IN+N_OUT+1 are misses. Beyond the upper bound, no wrap-around is decoded.

## Structure
- The `io_pkg` package holds:
  - the `A_W` localparam derivation;
  - the region enum `{REG_IN, REG_OUT, REG_STATUS, REG_NONE}`;
  - a decode function `(addr, BASE_ADDR, N_IN, N_OUT) → region + index`.
- Sub-module `io_debounce`, instantiated N_IN times via generate:
  - parameters WORD_W and DEB_CYCLES;
  - ports: clock, reset, raw, stable, changed;
  - contains the synchroniser and the counter.
- The top level holds MAR, MDR, the output registers, the flags, `irq` and the tristate.

## Test plan
All scenarios use the defaults: inputs at 24 and 25, outputs at 26 and 27, STATUS at 28.
- **Reset:** assert `reset` mid-traffic → all outputs 0, `sysbus` Z, `irq` 0, and a STATUS read returns 0x00.
- **Output write/readback:** MAR←26, MDR←0xA5, `CS`=1 with `R_NW`=0 → `port_out[7:0]`=0xA5. A read of 26 then yields `sysbus`=0xA5 under `MDR_bus`.
- **Debounce:** port 1 raw changes 0x00→0x3C.
  - Held 6 clocks → a read of 25 returns 0x3C, STATUS=0x02 and `irq`=1.
  - A 3-clock glitch → no change and STATUS=0x00.
- **Read-to-clear:** read 28 → MDR=0x02 and flags clear. Repeat with a `changed` pulse on the same cycle → the flag stays 1.
- **W1C:** flags=0x03, write 0x01 to 28 → flags=0x02 and `irq` stays 1.
- **Decode boundaries:** MAR=23, 29 or 31 with `MDR_bus` → `sysbus` stays Z. `load_MAR` and `CS` asserted together → only the MAR updates.

Source files
------------

// File: rtl/io_pkg.sv
// Shared types and helpers for the memory-mapped I/O port bank.
// Holds the address-width derivation, the region enum and the window decoder.
package io_pkg;

   localparam int WORD_W_DEF = 8;
   localparam int OP_W_DEF   = 3;
   localparam int A_W_DEF    = WORD_W_DEF - OP_W_DEF;

   // The address field is whatever the opcode leaves of the word.
   function automatic int addr_w(input int word_w, input int op_w);
      return word_w - op_w;
   endfunction

   typedef enum logic [1:0] {
      REG_IN,
      REG_OUT,
      REG_STATUS,
      REG_NONE
   } region_e;

   typedef struct packed {
      region_e     region;
      logic [15:0] index;
   } dec_t;

   // Maps an absolute address onto a region and an index inside it.
   // Anything outside [base, base+n_in+n_out] is REG_NONE.
   function automatic dec_t decode(input int unsigned addr,
                                   input int unsigned base,
                                   input int unsigned n_in,
                                   input int unsigned n_out);
      dec_t d;
      d.region = REG_NONE;
      d.index  = '0;
      if (addr >= base && addr < base + n_in) begin
         d.region = REG_IN;
         d.index  = 16'(addr - base);
      end else if (addr >= base + n_in &&
                   addr < base + n_in + n_out) begin
         d.region = REG_OUT;
         d.index  = 16'(addr - base - n_in);
      end else if (addr == base + n_in + n_out) begin
         d.region = REG_STATUS;
      end
      return d;
   endfunction

endpackage

// File: rtl/io_debounce.sv
// Input conditioner for one port: 2-flop synchroniser plus debouncer.
// Ports: clock, reset (async, high), raw (async input word),
//        stable (accepted value), changed (high the cycle before stable moves).
module io_debounce #(
   parameter int WORD_W     = 8,
   parameter int DEB_CYCLES = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [WORD_W-1:0] raw,
   output logic [WORD_W-1:0] stable,
   output logic              changed
);

   localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEB_CYCLES - 1);

   logic [WORD_W-1:0] sync1;
   logic [WORD_W-1:0] sync2;
   logic [CNT_W-1:0]  cnt;
   logic              differ;

   assign differ = (sync2 != stable);

   // Combinational so that the status flag captures on the same edge
   // that stable takes the new value.
   assign changed = differ && (cnt == LAST);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1  <= '0;
         sync2  <= '0;
         stable <= '0;
         cnt    <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         if (!differ) begin
            cnt <= '0;
         end else if (cnt == LAST) begin
            // Whatever differing value is present now is the one taken.
            stable <= sync2;
            cnt    <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/io_port_bank.sv
// Memory-mapped I/O port bank on the shared sysbus: debounced inputs,
// read-back output registers and a change-status register with irq.
// Ports: clock, reset (async, high); MDR_bus/load_MAR/load_MDR/CS/R_NW
//        bus controls; sw_in raw inputs; port_out outputs; irq; sysbus.
module io_port_bank
   import io_pkg::*;
#(
   parameter int WORD_W     = 8,
   parameter int OP_W       = 3,
   parameter int N_IN       = 2,
   parameter int N_OUT      = 2,
   parameter int BASE_ADDR  = 24,
   parameter int DEB_CYCLES = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    MDR_bus,
   input  logic                    load_MAR,
   input  logic                    load_MDR,
   input  logic                    CS,
   input  logic                    R_NW,
   input  logic [N_IN*WORD_W-1:0]  sw_in,
   output logic [N_OUT*WORD_W-1:0] port_out,
   output logic                    irq,
   inout  wire  [WORD_W-1:0]       sysbus
);

   localparam int A_W = addr_w(WORD_W, OP_W);

   logic [A_W-1:0]    mar;
   logic [WORD_W-1:0] mdr;
   logic [WORD_W-1:0] outs [N_OUT];
   logic [WORD_W-1:0] stab [N_IN];
   logic [N_IN-1:0]   chg;
   logic [N_IN-1:0]   flags;
   logic [N_IN-1:0]   clr_f;
   logic [WORD_W-1:0] rd_val;
   dec_t              dec;
   logic              hit;
   logic              rd_acc;
   logic              wr_acc;

   assign dec = decode(32'(mar), BASE_ADDR, N_IN, N_OUT);
   assign hit = (dec.region != REG_NONE);

   // load_MAR and load_MDR both outrank an access in the same cycle.
   assign rd_acc = CS &  R_NW & hit & ~load_MAR & ~load_MDR;
   assign wr_acc = CS & ~R_NW & hit & ~load_MAR & ~load_MDR;

   for (genvar g = 0; g < N_IN; g++) begin : g_in
      io_debounce #(
         .WORD_W    (WORD_W),
         .DEB_CYCLES(DEB_CYCLES)
      ) u_deb (
         .clock  (clock),
         .reset  (reset),
         .raw    (sw_in[g*WORD_W +: WORD_W]),
         .stable (stab[g]),
         .changed(chg[g])
      );
   end

   for (genvar g = 0; g < N_OUT; g++) begin : g_out
      assign port_out[g*WORD_W +: WORD_W] = outs[g];
   end

   always_comb begin
      rd_val = '0;
      case (dec.region)
         REG_IN: begin
            for (int i = 0; i < N_IN; i++)
               if (dec.index == 16'(i)) rd_val = stab[i];
         end
         REG_OUT: begin
            for (int i = 0; i < N_OUT; i++)
               if (dec.index == 16'(i)) rd_val = outs[i];
         end
         REG_STATUS: rd_val = WORD_W'(flags);
         default:    rd_val = '0;
      endcase
   end

   // A STATUS read clears everything; a STATUS write clears the 1 bits.
   always_comb begin
      clr_f = '0;
      if (dec.region == REG_STATUS) begin
         if (rd_acc)      clr_f = '1;
         else if (wr_acc) clr_f = mdr[N_IN-1:0];
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mar <= '0;
         mdr <= '0;
      end else if (load_MAR) begin
         mar <= sysbus[A_W-1:0];
      end else if (load_MDR) begin
         mdr <= sysbus;
      end else if (rd_acc) begin
         mdr <= rd_val;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N_OUT; i++) outs[i] <= '0;
      end else if (wr_acc && dec.region == REG_OUT) begin
         for (int i = 0; i < N_OUT; i++)
            if (dec.index == 16'(i)) outs[i] <= mdr;
      end
   end

   // Set after clear so a simultaneous change pulse wins.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         flags <= '0;
         irq   <= 1'b0;
      end else begin
         flags <= (flags & ~clr_f) | chg;
         irq   <= |flags;
      end
   end

   assign sysbus = (MDR_bus && hit) ? mdr : {WORD_W{1'bz}};

endmodule
